// File: rtl/handshake_pkg.sv
// ============================================================================
// Module   : handshake_pkg
// Brief    : Shared state encoding and start-mode constants for handshake_mc.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package handshake_pkg;

  typedef enum logic [0:0] {
    HS_IDLE = 1'b0,
    HS_WAIT = 1'b1
  } hs_state_t;

  localparam int START_PULSE = 0;
  localparam int START_LEVEL = 1;

endpackage

`default_nettype wire

// File: rtl/handshake_mc_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter; scans upward from ptr+1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [ID_W-1:0]   ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [ID_W-1:0]   gnt_id,
  output logic              any_gnt
);

  int              w_idx;
  logic [ID_W-1:0] w_sel;

  // Offset 1 first so the last winner gets the lowest priority.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    any_gnt = 1'b0;
    w_idx   = 0;
    w_sel   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_idx = int'(ptr) + k;
      if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
      w_sel = ID_W'(w_idx);
      if (!any_gnt && req[w_sel]) begin
        any_gnt    = 1'b1;
        gnt[w_sel] = 1'b1;
        gnt_id     = w_sel;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/handshake_mc.sv
// ============================================================================
// Module   : handshake_mc
// Brief    : Multi-channel start/done sequencer with round-robin grant and
//            per-channel sticky watchdog errors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module handshake_mc
  import handshake_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int TMO_W      = 8,
  parameter int START_MODE = 0
) (
  input  logic                      clk,
  input  logic                      rst_l,
  input  logic [NUM_CH-1:0]         ready,
  input  logic [NUM_CH-1:0]         done,
  input  logic [TMO_W-1:0]          timeout_cyc,
  input  logic [NUM_CH-1:0]         err_clr,
  output logic [NUM_CH-1:0]         start,
  output logic                      busy,
  output logic [$clog2(NUM_CH)-1:0] grant_id,
  output logic                      done_o,
  output logic [NUM_CH-1:0]         tmo_err
);

  localparam int ID_W = $clog2(NUM_CH);
  localparam logic [TMO_W-1:0] c_tmr_max = {TMO_W{1'b1}};

  hs_state_t         r_state;
  logic [ID_W-1:0]   r_ptr;
  logic [TMO_W-1:0]  r_timer;

  logic [NUM_CH-1:0] w_elig;
  logic [NUM_CH-1:0] w_gnt;
  logic [ID_W-1:0]   w_gnt_id;
  logic              w_any;
  logic              w_tmo_hit;

  assign w_elig    = ready & ~tmo_err;
  assign w_tmo_hit = (timeout_cyc != '0) && (r_timer == timeout_cyc - TMO_W'(1));

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) u_arb (
    .req     (w_elig),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_id  (w_gnt_id),
    .any_gnt (w_any)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state  <= HS_IDLE;
      r_ptr    <= ID_W'(NUM_CH - 1);
      r_timer  <= '0;
      start    <= '0;
      busy     <= 1'b0;
      grant_id <= '0;
      done_o   <= 1'b0;
      tmo_err  <= '0;
    end else begin
      done_o  <= 1'b0;
      // A timeout set later in this block overrides a coincident clear.
      tmo_err <= tmo_err & ~err_clr;
      case (r_state)
        HS_IDLE: begin
          start <= '0;
          if (w_any) begin
            start    <= w_gnt;
            grant_id <= w_gnt_id;
            r_timer  <= '0;
            busy     <= 1'b1;
            r_state  <= HS_WAIT;
          end
        end
        HS_WAIT: begin
          if (START_MODE == START_PULSE) start <= '0;
          if (done[grant_id]) begin
            done_o  <= 1'b1;
            r_ptr   <= grant_id;
            start   <= '0;
            busy    <= 1'b0;
            r_state <= HS_IDLE;
          end else if (w_tmo_hit) begin
            tmo_err[grant_id] <= 1'b1;
            r_ptr   <= grant_id;
            start   <= '0;
            busy    <= 1'b0;
            r_state <= HS_IDLE;
          end else if (r_timer != c_tmr_max) begin
            r_timer <= r_timer + TMO_W'(1);
          end
        end
        default: r_state <= HS_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
